tile_addr_gen: RTL and testbench
================================

# tile_addr_gen

Parametrised BRAM tile address generator for the arbiter fetch/write path. It issues a burst of sequential BRAM accesses per tile in either read (fetch) or write mode, with a programmable base address, tile stride, burst length and tile count. It interleaves tiles across banks and honours a downstream stall. It sits between the arbiter control FSM and the BRAM port muxes, driving one BRAM port group per instance.

## Interface
- ADDR_WIDTH, 11, BRAM address width
- MAX_BURST, 16, maximum beats per tile (≥1)
- TILE_W, 9, tile pointer / tile count width
- NUM_BANKS, 2, banks interleaved by tile index (≥1); BANK_W = max(1,$clog2(NUM_BANKS))
- BL_W, derived, $clog2(MAX_BURST+1)

- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request one tile burst; accepted when ready=1
- mode  in  1  0 = read (fetch), 1 = write; sampled on accepted start
- burst_len  in  BL_W  beats for this tile, sampled on accepted start; legal range 1..MAX_BURST
- base_addr  in  ADDR_WIDTH  start address of tile 0; sampled on accepted start
- tile_stride  in  ADDR_WIDTH  address step between tiles; sampled on accepted start
- num_tiles  in  TILE_W  tiles before the pointer wraps; sampled on accepted start; 0 means 2^TILE_W
- reset_tile_ptr  in  1  synchronous clear of the tile pointer
- stall  in  1  downstream not ready; freezes the current beat
- ready  out  1  block can accept start (IDLE or DONE)
- busy  out  1  burst in progress (ACTIVE)
- bram_addr  out  ADDR_WIDTH  access address
- bram_en  out  1  access strobe
- bram_we  out  1  write strobe
- bank_sel  out  BANK_W  target bank = tile_ptr mod NUM_BANKS
- done  out  1  one-cycle pulse after the last beat of a tile
- last_tile  out  1  qualifies done: the tile just finished was index num_tiles-1
- tile_ptr  out  TILE_W  current tile index

## Operation
- States: IDLE, ACTIVE, DONE.
- IDLE:
  - start with a legal burst_len → ACTIVE. mode, burst_len, base_addr, tile_stride and num_tiles are latched.
  - start with burst_len=0 or burst_len>MAX_BURST is ignored: no state change, no done.
- ACTIVE:
  - Each cycle with stall=0 is a beat: bram_en=1, bram_we=latched mode, and the beat offset increments.
  - With stall=1: bram_en=bram_we=0; offset and address hold.
  - The beat with offset=burst_len-1 and stall=0 → DONE.
- DONE:
  - done=1 for one cycle.
  - tile_ptr advances on exit. It wraps to 0 when tile_ptr = num_tiles-1; last_tile=1 in that DONE cycle.
  - start with a legal burst_len in DONE → ACTIVE directly (back-to-back). Otherwise → IDLE.
- Address: bram_addr = base_addr + tile_ptr*tile_stride + offset, computed at full precision and truncated mod 2^ADDR_WIDTH. Wrap-around is legal and silent.
- reset_tile_ptr:
  - Clears tile_ptr to 0 in any state and has priority over the DONE increment.
  - Asserted during ACTIVE, it retargets the remaining beats of the current burst to tile 0. Software must avoid this.
- start while busy=1 is ignored.
- stall is a don't-care outside ACTIVE.
- Outputs are decoded from registered state. The only input→output combinational path is stall → bram_en/bram_we.

## Timing
- Reset values:
  - state=IDLE
  - ready=1
  - busy=0, bram_en=0, bram_we=0, done=0, last_tile=0
  - bram_addr=base_addr at power-up latch value 0, i.e. 0
  - bank_sel=0, tile_ptr=0
  - offset=0
  - all latched config registers = 0
- Latency: start accepted at cycle 0 → first beat cycle 1. An unstalled burst of N beats occupies cycles 1..N; done is in cycle N+1.
- Each stalled cycle adds one cycle of latency.
- Back-to-back: start held high gives a next first beat at cycle N+2, i.e. one dead cycle per tile.
- rst_n assertion mid-burst: immediate return to IDLE with reset values. No done pulse; the partial burst is abandoned.

## Test plan
- Reset mid-burst: assert rst_n low during beat 2 → bram_en=0 and busy=0 immediately, tile_ptr=0, no done pulse.
- Single read tile: base=0, stride=4, burst_len=4, mode=0, start → addrs 0,1,2,3 in cycles 1-4 with en=1 and we=0; done in cycle 5; tile_ptr=1; bank_sel=1.
- Write tiles with wrap: num_tiles=3, stride=8, burst_len=2, mode=1, three starts held back-to-back → addrs 0,1 / 8,9 / 16,17 with we=1; last_tile=1 only on the third done; tile_ptr returns to 0.
- Stall: burst_len=3; stall high during cycles 2-3 → addr 1 held; beats at cycles 1, 4, 5; done at cycle 6; en=0 while stalled.
- Address wrap: ADDR_WIDTH=11, base=2046, burst_len=4 → addrs 2046, 2047, 0, 1.
- Illegal/ignored starts: burst_len=0 → stays IDLE. start during ACTIVE → no effect. reset_tile_ptr together with done → tile_ptr=0, not incremented.

Source files
------------

// File: rtl/tile_addr_gen.sv
// tile_addr_gen
// BRAM tile address generator. One burst of sequential BRAM accesses is issued
// per accepted start. Tiles are walked through a wrapping tile pointer, and
// each tile is steered to a bank chosen by its tile index. A downstream stall
// freezes the current beat.
//
// Address of a beat = base + tile_ptr * stride + offset, modulo 2^ADDR_WIDTH.
// All outputs come from registered state, except that stall gates bram_en and
// bram_we combinationally so a stalled beat never reaches the BRAM port.

module tile_addr_gen #(
    parameter  int ADDR_WIDTH = 11,
    parameter  int MAX_BURST  = 16,
    parameter  int TILE_W     = 9,
    parameter  int NUM_BANKS  = 2,
    localparam int BANK_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
    localparam int BL_W       = $clog2(MAX_BURST + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  mode,
    input  logic [BL_W-1:0]       burst_len,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] tile_stride,
    input  logic [TILE_W-1:0]     num_tiles,
    input  logic                  reset_tile_ptr,
    input  logic                  stall,
    output logic                  ready,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic                  bram_en,
    output logic                  bram_we,
    output logic [BANK_W-1:0]     bank_sel,
    output logic                  done,
    output logic                  last_tile,
    output logic [TILE_W-1:0]     tile_ptr
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registered state and latched burst configuration
    // ------------------------------------------------------------------
    state_t                  state_reg,      state_next;
    logic                    mode_reg,       mode_next;
    logic [BL_W-1:0]         burst_len_reg,  burst_len_next;
    logic [ADDR_WIDTH-1:0]   base_reg,       base_next;
    logic [ADDR_WIDTH-1:0]   stride_reg,     stride_next;
    logic [TILE_W-1:0]       num_tiles_reg,  num_tiles_next;
    logic [TILE_W-1:0]       tile_ptr_reg,   tile_ptr_next;
    logic [BL_W-1:0]         offset_reg,     offset_next;

    // ------------------------------------------------------------------
    // Decodes shared by the next-state logic and the outputs
    // ------------------------------------------------------------------
    logic                    start_legal;
    logic                    last_beat;
    logic                    tile_wrap;
    logic                    cfg_load;
    logic [ADDR_WIDTH-1:0]   tile_offset;

    // A start is only honoured with a burst length in 1..MAX_BURST; anything
    // else is silently dropped so a bad request never enters ACTIVE.
    assign start_legal = start
                       && (burst_len != '0)
                       && (burst_len <= BL_W'(MAX_BURST));

    // Final beat of the burst: burst_len_reg is never zero while ACTIVE.
    assign last_beat   = (offset_reg == (burst_len_reg - BL_W'(1)));

    // num_tiles == 0 encodes 2^TILE_W tiles; the subtraction then yields the
    // all-ones index, which is exactly the last reachable pointer value.
    assign tile_wrap   = (tile_ptr_reg == (num_tiles_reg - TILE_W'(1)));

    // The low ADDR_WIDTH bits of a product depend only on the low ADDR_WIDTH
    // bits of its operands, so an ADDR_WIDTH-wide multiply gives the full
    // precision result already reduced modulo 2^ADDR_WIDTH.
    assign tile_offset = stride_reg * ADDR_WIDTH'(tile_ptr_reg);

    // ------------------------------------------------------------------
    // Next-state, pointer and configuration logic
    // ------------------------------------------------------------------
    // Compute the FSM transition, beat offset and tile pointer for the next cycle.
    always_comb begin
        state_next     = state_reg;
        mode_next      = mode_reg;
        burst_len_next = burst_len_reg;
        base_next      = base_reg;
        stride_next    = stride_reg;
        num_tiles_next = num_tiles_reg;
        tile_ptr_next  = tile_ptr_reg;
        offset_next    = offset_reg;
        cfg_load       = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start_legal) begin
                    state_next = ST_ACTIVE;
                    cfg_load   = 1'b1;
                end
            end

            ST_ACTIVE: begin
                // A stalled cycle is not a beat: offset and address hold.
                if (!stall) begin
                    if (last_beat) begin
                        state_next  = ST_DONE;
                        offset_next = '0;
                    end else begin
                        offset_next = offset_reg + BL_W'(1);
                    end
                end
            end

            ST_DONE: begin
                // Leaving DONE always moves on to the next tile.
                if (tile_wrap) begin
                    tile_ptr_next = '0;
                end else begin
                    tile_ptr_next = tile_ptr_reg + TILE_W'(1);
                end
                // Back-to-back tiles skip IDLE, costing one dead cycle per tile.
                if (start_legal) begin
                    state_next = ST_ACTIVE;
                    cfg_load   = 1'b1;
                end else begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Capture the request parameters whenever a burst is accepted.
        if (cfg_load) begin
            mode_next      = mode;
            burst_len_next = burst_len;
            base_next      = base_addr;
            stride_next    = tile_stride;
            num_tiles_next = num_tiles;
            offset_next    = '0;
        end

        // Pointer clear wins over the DONE increment. Used mid-burst it
        // redirects the remaining beats to tile 0, which callers must avoid.
        if (reset_tile_ptr) begin
            tile_ptr_next = '0;
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // Hold FSM state, tile pointer, beat offset and latched configuration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            mode_reg      <= 1'b0;
            burst_len_reg <= '0;
            base_reg      <= '0;
            stride_reg    <= '0;
            num_tiles_reg <= '0;
            tile_ptr_reg  <= '0;
            offset_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            mode_reg      <= mode_next;
            burst_len_reg <= burst_len_next;
            base_reg      <= base_next;
            stride_reg    <= stride_next;
            num_tiles_reg <= num_tiles_next;
            tile_ptr_reg  <= tile_ptr_next;
            offset_reg    <= offset_next;
        end
    end

    // ------------------------------------------------------------------
    // Bank selection: tile index modulo NUM_BANKS
    // ------------------------------------------------------------------
    generate
        if (NUM_BANKS == 1) begin : g_single_bank
            assign bank_sel = '0;
        end else if ((NUM_BANKS & (NUM_BANKS - 1)) == 0) begin : g_pow2_banks
            // Power-of-two bank count: the modulo is just the low pointer bits.
            assign bank_sel = tile_ptr_reg[BANK_W-1:0];
        end else begin : g_mod_banks
            logic [TILE_W-1:0] bank_full;
            assign bank_full = tile_ptr_reg % TILE_W'(NUM_BANKS);
            assign bank_sel  = bank_full[BANK_W-1:0];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ready     = (state_reg == ST_IDLE) || (state_reg == ST_DONE);
    assign busy      = (state_reg == ST_ACTIVE);
    assign bram_en   = busy && !stall;
    assign bram_we   = bram_en && mode_reg;
    assign bram_addr = base_reg + tile_offset + ADDR_WIDTH'(offset_reg);
    assign done      = (state_reg == ST_DONE);
    assign last_tile = done && tile_wrap;
    assign tile_ptr  = tile_ptr_reg;

endmodule

// File: tb/tb_tile_addr_gen.sv
// Testbench for tile_addr_gen.
// The stimulus process pushes the expected BRAM beats, done pulses and status
// snapshots into queues. A separate monitor process pops and compares them on
// the falling clock edge, whenever the DUT presents a beat or a done pulse, or
// a status snapshot is pending.

module tb_tile_addr_gen;

    localparam int ADDR_WIDTH = 11;
    localparam int MAX_BURST  = 16;
    localparam int TILE_W     = 9;
    localparam int NUM_BANKS  = 2;
    localparam int BANK_W     = 1;
    localparam int BL_W       = 5;

    logic                  clk            = 1'b0;
    logic                  rst_n          = 1'b0;
    logic                  start          = 1'b0;
    logic                  mode           = 1'b0;
    logic [BL_W-1:0]       burst_len      = '0;
    logic [ADDR_WIDTH-1:0] base_addr      = '0;
    logic [ADDR_WIDTH-1:0] tile_stride    = '0;
    logic [TILE_W-1:0]     num_tiles      = '0;
    logic                  reset_tile_ptr = 1'b0;
    logic                  stall          = 1'b0;
    logic                  ready;
    logic                  busy;
    logic [ADDR_WIDTH-1:0] bram_addr;
    logic                  bram_en;
    logic                  bram_we;
    logic [BANK_W-1:0]     bank_sel;
    logic                  done;
    logic                  last_tile;
    logic [TILE_W-1:0]     tile_ptr;

    always #5 clk = ~clk;

    tile_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .MAX_BURST  (MAX_BURST),
        .TILE_W     (TILE_W),
        .NUM_BANKS  (NUM_BANKS)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .mode           (mode),
        .burst_len      (burst_len),
        .base_addr      (base_addr),
        .tile_stride    (tile_stride),
        .num_tiles      (num_tiles),
        .reset_tile_ptr (reset_tile_ptr),
        .stall          (stall),
        .ready          (ready),
        .busy           (busy),
        .bram_addr      (bram_addr),
        .bram_en        (bram_en),
        .bram_we        (bram_we),
        .bank_sel       (bank_sel),
        .done           (done),
        .last_tile      (last_tile),
        .tile_ptr       (tile_ptr)
    );

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  we;
        logic [BANK_W-1:0]     bank;
    } beat_t;

    typedef struct packed {
        logic              last;
        logic [TILE_W-1:0] tp;
    } done_t;

    typedef struct packed {
        logic [7:0]            id;
        logic                  fin;
        logic                  rdy;
        logic                  bsy;
        logic                  en;
        logic                  we;
        logic                  dn;
        logic                  last;
        logic [TILE_W-1:0]     tp;
        logic [BANK_W-1:0]     bank;
        logic [ADDR_WIDTH-1:0] addr;
    } probe_t;

    beat_t  beat_q[$];
    done_t  done_q[$];
    probe_t probe_q[$];

    int checks     = 0;
    int errors     = 0;
    bit final_seen = 1'b0;

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_beat(input int a, input bit we, input int bank);
        beat_t b;
        b.addr = ADDR_WIDTH'(a);
        b.we   = we;
        b.bank = BANK_W'(bank);
        beat_q.push_back(b);
    endtask

    task automatic exp_done(input bit last, input int tp);
        done_t d;
        d.last = last;
        d.tp   = TILE_W'(tp);
        done_q.push_back(d);
    endtask

    task automatic probe(input int id, input bit rdy, input bit bsy,
                         input bit en, input bit we, input bit dn,
                         input bit last, input int tp, input int bank,
                         input int addr);
        probe_t p;
        p.id   = 8'(id);
        p.fin  = 1'b0;
        p.rdy  = rdy;
        p.bsy  = bsy;
        p.en   = en;
        p.we   = we;
        p.dn   = dn;
        p.last = last;
        p.tp   = TILE_W'(tp);
        p.bank = BANK_W'(bank);
        p.addr = ADDR_WIDTH'(addr);
        probe_q.push_back(p);
    endtask

    task automatic probe_final();
        probe_t p;
        p     = '0;
        p.id  = 8'd99;
        p.fin = 1'b1;
        probe_q.push_back(p);
    endtask

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    initial begin
        beat_t  b;
        done_t  d;
        probe_t p;
        forever begin
            @(negedge clk);
            if (bram_en === 1'b1) begin
                checks++;
                if (beat_q.size() == 0) begin
                    errors++;
                    $display("FAIL beat: got addr=%0d we=%0d bank=%0d, expected no access",
                             bram_addr, bram_we, bank_sel);
                end else begin
                    b = beat_q.pop_front();
                    if (bram_addr !== b.addr || bram_we !== b.we || bank_sel !== b.bank) begin
                        errors++;
                        $display("FAIL beat: got addr=%0d we=%0d bank=%0d, expected addr=%0d we=%0d bank=%0d",
                                 bram_addr, bram_we, bank_sel, b.addr, b.we, b.bank);
                    end else begin
                        $display("beat addr=%0d we=%0d bank=%0d ok", bram_addr, bram_we, bank_sel);
                    end
                end
            end
            if (done === 1'b1) begin
                checks++;
                if (done_q.size() == 0) begin
                    errors++;
                    $display("FAIL done: got done pulse tile_ptr=%0d last_tile=%0d, expected none",
                             tile_ptr, last_tile);
                end else begin
                    d = done_q.pop_front();
                    if (last_tile !== d.last || tile_ptr !== d.tp) begin
                        errors++;
                        $display("FAIL done: got tile_ptr=%0d last_tile=%0d, expected tile_ptr=%0d last_tile=%0d",
                                 tile_ptr, last_tile, d.tp, d.last);
                    end else begin
                        $display("done tile_ptr=%0d last_tile=%0d ok", tile_ptr, last_tile);
                    end
                end
            end
            if (probe_q.size() != 0) begin
                p = probe_q.pop_front();
                checks++;
                if (p.fin) begin
                    if (beat_q.size() != 0 || done_q.size() != 0) begin
                        errors++;
                        $display("FAIL drain: got %0d beats and %0d dones outstanding, expected 0 and 0",
                                 beat_q.size(), done_q.size());
                    end else begin
                        $display("drain ok");
                    end
                    final_seen = 1'b1;
                end else if (ready !== p.rdy || busy !== p.bsy || bram_en !== p.en ||
                             bram_we !== p.we || done !== p.dn || last_tile !== p.last ||
                             tile_ptr !== p.tp || bank_sel !== p.bank || bram_addr !== p.addr) begin
                    errors++;
                    $display("FAIL status%0d: got rdy=%0d busy=%0d en=%0d we=%0d done=%0d last=%0d tp=%0d bank=%0d addr=%0d, expected rdy=%0d busy=%0d en=%0d we=%0d done=%0d last=%0d tp=%0d bank=%0d addr=%0d",
                             p.id, ready, busy, bram_en, bram_we, done, last_tile, tile_ptr, bank_sel, bram_addr,
                             p.rdy, p.bsy, p.en, p.we, p.dn, p.last, p.tp, p.bank, p.addr);
                end else begin
                    $display("status%0d ok", p.id);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
    initial begin
        #20000;
        $display("FAIL watchdog: got simulation still running at %0t, expected finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        probe(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // Single read tile, with an ignored start during ACTIVE
        base_addr = 0; tile_stride = 4; burst_len = 4; mode = 0; num_tiles = 0;
        start = 1;                                        // cycle 0
        for (int a = 0; a < 4; a++) exp_beat(a, 0, 0);
        exp_done(0, 0);
        tick(); start = 0;                                // cycle 1
        probe(2, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        tick(); start = 1; base_addr = 100;               // cycle 2
        tick(); start = 0; base_addr = 0;                 // cycle 3
        tick();                                           // cycle 4
        tick();                                           // cycle 5: done
        probe(3, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        tick();                                           // cycle 6: idle
        probe(4, 1, 0, 0, 0, 0, 0, 1, 1, 4);

        // Asynchronous reset during beat 2
        tick();
        mode = 1; start = 1;                              // cycle 0
        exp_beat(4, 1, 1);
        tick(); start = 0;                                // cycle 1
        tick(); rst_n = 0;                                // cycle 2
        probe(5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(); rst_n = 1;
        probe(6, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();

        // Back-to-back write tiles with pointer wrap after three tiles
        mode = 1; base_addr = 0; tile_stride = 8; burst_len = 2; num_tiles = 3;
        start = 1;                                        // cycle 0
        exp_beat(0, 1, 0);  exp_beat(1, 1, 0);
        exp_beat(8, 1, 1);  exp_beat(9, 1, 1);
        exp_beat(16, 1, 0); exp_beat(17, 1, 0);
        exp_done(0, 0); exp_done(0, 1); exp_done(1, 2);
        repeat (4) tick();                                // cycle 4
        probe(7, 0, 1, 1, 1, 0, 0, 1, 1, 8);
        repeat (5) tick();                                // cycle 9: third done
        start = 0;
        probe(8, 1, 0, 0, 0, 1, 1, 2, 0, 16);
        tick();                                           // cycle 10
        probe(9, 1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Stall during cycles 2-3
        tick();
        mode = 0; burst_len = 3; tile_stride = 4; base_addr = 0; num_tiles = 0;
        start = 1;                                        // cycle 0
        exp_beat(0, 0, 0); exp_beat(1, 0, 0); exp_beat(2, 0, 0);
        exp_done(0, 0);
        tick(); start = 0;                                // cycle 1
        tick(); stall = 1;                                // cycle 2
        probe(10, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        tick();                                           // cycle 3
        probe(11, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        tick(); stall = 0;                                // cycle 4
        tick();                                           // cycle 5
        tick();                                           // cycle 6: done
        probe(12, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        tick();                                           // cycle 7

        // Address wrap-around at 2^ADDR_WIDTH (tile 1, stride 0)
        mode = 1; base_addr = 2046; tile_stride = 0; burst_len = 4;
        start = 1;                                        // cycle 0
        exp_beat(2046, 1, 1); exp_beat(2047, 1, 1);
        exp_beat(0, 1, 1);    exp_beat(1, 1, 1);
        exp_done(0, 1);
        tick(); start = 0;                                // cycle 1
        repeat (5) tick();                                // cycle 6
        probe(13, 1, 0, 0, 0, 0, 0, 2, 0, 2046);

        // Illegal burst lengths are ignored
        tick();
        burst_len = 0; start = 1;
        tick();
        probe(14, 1, 0, 0, 0, 0, 0, 2, 0, 2046);
        burst_len = 17;
        tick();
        probe(15, 1, 0, 0, 0, 0, 0, 2, 0, 2046);
        start = 0;
        tick();

        // reset_tile_ptr coinciding with done wins over the increment
        mode = 0; base_addr = 0; tile_stride = 4; burst_len = 1; num_tiles = 0;
        start = 1;                                        // cycle 0
        exp_beat(8, 0, 0);
        exp_done(0, 2);
        tick(); start = 0;                                // cycle 1
        tick(); reset_tile_ptr = 1;                       // cycle 2: done
        probe(16, 1, 0, 0, 0, 1, 0, 2, 0, 8);
        tick();                                           // cycle 3
        probe(17, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        reset_tile_ptr = 0;
        tick();

        // Every expected beat and done must have been consumed
        probe_final();
        for (int i = 0; i < 10 && !final_seen; i++) tick();
        if (!final_seen) begin
            $display("FAIL drain: got no final scoreboard check, expected one");
            $fatal(1, "scoreboard drain not reached");
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
